// File: rtl/ps2_key_rx_if.sv
// PS/2 key receiver bus: raw keyboard pins in, key events out.
// Master drives the pins; slave is the receiver.
interface ps2_key_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  modport master (
    output ps2_clk, ps2_data,
    input  ps2_key, frame_err, busy
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output ps2_key, frame_err, busy
  );
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 device-to-host deframer with prefix folding into ps2_key events.
// Optional PS2_REPEAT_FILTER_EN suppresses repeated identical makes.
module ps2_key_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 26000
) (
  input logic          clk_sys,
  input logic          reset_n,
  ps2_key_rx_if.slave  bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_DATA, S_PARITY, S_STOP
  } state_t;

  logic [1:0]    clk_s_q, dat_s_q;
  logic [FW-1:0] clk_n_q, dat_n_q;
  logic          clk_f_q, dat_f_q, clk_fp_q;
  logic          fe;

  state_t        state_q;
  logic [2:0]    bit_q;
  logic [7:0]    sr_q;
  logic          par_q;
  logic          acc_q;
  logic          err_q;
  logic [TW-1:0] to_q;

  logic [10:0]   key_q;
  logic          ext_q, brk_q;
  logic [2:0]    skip_q;
  logic          is_ack;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s_q  <= 2'b11;
      dat_s_q  <= 2'b11;
      clk_n_q  <= '0;
      dat_n_q  <= '0;
      clk_f_q  <= 1'b1;
      dat_f_q  <= 1'b1;
      clk_fp_q <= 1'b1;
    end else begin
      clk_s_q  <= {clk_s_q[0], bus.ps2_clk};
      dat_s_q  <= {dat_s_q[0], bus.ps2_data};
      clk_fp_q <= clk_f_q;
      if (clk_s_q[1] == clk_f_q) begin
        clk_n_q <= '0;
      end else if (clk_n_q == FW'(FILTER_LEN - 1)) begin
        clk_f_q <= clk_s_q[1];
        clk_n_q <= '0;
      end else begin
        clk_n_q <= clk_n_q + FW'(1);
      end
      if (dat_s_q[1] == dat_f_q) begin
        dat_n_q <= '0;
      end else if (dat_n_q == FW'(FILTER_LEN - 1)) begin
        dat_f_q <= dat_s_q[1];
        dat_n_q <= '0;
      end else begin
        dat_n_q <= dat_n_q + FW'(1);
      end
    end
  end

  assign fe = clk_fp_q & ~clk_f_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      acc_q   <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= '0;
    end else begin
      acc_q <= 1'b0;
      err_q <= 1'b0;
      if (fe) begin
        to_q <= '0;
        unique case (state_q)
          S_IDLE: begin
            if (!dat_f_q) begin
              state_q <= S_DATA;
              bit_q   <= '0;
            end
          end
          S_DATA: begin
            sr_q  <= {dat_f_q, sr_q[7:1]};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7)
              state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q   <= dat_f_q;
            state_q <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (dat_f_q && (^{sr_q, par_q}))
              acc_q <= 1'b1;
            else
              err_q <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q == S_IDLE) begin
        to_q <= '0;
      end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
        state_q <= S_IDLE;
        err_q   <= 1'b1;
        to_q    <= '0;
      end else begin
        to_q <= to_q + TW'(1);
      end
    end
  end

  // Host-protocol replies carry no key information
  assign is_ack = (sr_q == 8'hFA) || (sr_q == 8'hAA) ||
                  (sr_q == 8'hEE) || (sr_q == 8'hFE);

`ifdef PS2_REPEAT_FILTER_EN
  logic [8:0] rpt_q;
  logic       rpt_vld_q;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      key_q     <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      skip_q    <= '0;
`ifdef PS2_REPEAT_FILTER_EN
      rpt_q     <= '0;
      rpt_vld_q <= 1'b0;
`endif
    end else if (err_q) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (acc_q) begin
      priority case (1'b1)
        skip_q != 3'd0: skip_q <= skip_q - 3'd1;
        sr_q == 8'hE1:  skip_q <= 3'd7;
        sr_q == 8'hE0:  ext_q  <= 1'b1;
        sr_q == 8'hF0:  brk_q  <= 1'b1;
        is_ack: begin
        end
        default: begin
`ifdef PS2_REPEAT_FILTER_EN
          if (brk_q || !rpt_vld_q || rpt_q != {ext_q, sr_q})
            key_q <= {~key_q[10], ~brk_q, ext_q, sr_q};
          if (brk_q) begin
            rpt_vld_q <= 1'b0;
          end else begin
            rpt_vld_q <= 1'b1;
            rpt_q     <= {ext_q, sr_q};
          end
`else
          key_q <= {~key_q[10], ~brk_q, ext_q, sr_q};
`endif
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ps2_key   = key_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: frames, prefixes, errors,
// timeout, Pause swallowing, glitch rejection and repeats.
`timescale 1ns/1ps
module tb_ps2_key_rx;
  localparam int H = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_key_rx_if bus();

  ps2_key_rx #(
    .FILTER_LEN (8),
    .TIMEOUT_CYC(200)
  ) dut (
    .clk_sys(clk),
    .reset_n(rst_n),
    .bus    (bus.slave)
  );

  int   checks = 0;
  int   failures = 0;
  int   err_cnt = 0;
  int   tgl_cnt = 0;
  bit   err_prev = 0;
  bit   err_long = 0;
  bit   busy_seen = 0;
  logic last_tgl = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_err) err_cnt++;
      if (bus.frame_err && err_prev) err_long = 1;
      err_prev = bus.frame_err;
      if (bus.ps2_key[10] !== last_tgl) tgl_cnt++;
      last_tgl = bus.ps2_key[10];
      if (bus.busy) busy_seen = 1;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(logic b);
    bus.ps2_data = b;
    cyc(H);
    bus.ps2_clk = 1'b0;
    cyc(H);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] b, logic pflip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ pflip);
    send_bit(1'b1);
    bus.ps2_data = 1'b1;
    cyc(60);
  endtask

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (bus.ps2_key !== 11'h000) begin
      failures++;
      $display("FAIL reset_key got=%h exp=000", bus.ps2_key);
    end
    checks++;
    if (bus.frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err got=%b exp=0", bus.frame_err);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_make;
    int e0, t0;
    e0 = err_cnt;
    t0 = tgl_cnt;
    send_frame(8'h1C, 1'b0);
    chk("make_key", 32'(bus.ps2_key), 32'h61C);
    chk("make_tgl", 32'(tgl_cnt - t0), 32'd1);
    chk("make_err", 32'(err_cnt - e0), 32'd0);
  endtask

  task automatic test_ext_break;
    int t0;
    t0 = tgl_cnt;
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    chk("pfx_notgl", 32'(tgl_cnt - t0), 32'd0);
    send_frame(8'h75, 1'b0);
    chk("extbrk_key", 32'(bus.ps2_key), 32'h175);
    chk("extbrk_tgl", 32'(tgl_cnt - t0), 32'd1);
  endtask

  task automatic test_parity_err;
    int e0;
    e0 = err_cnt;
    err_long = 0;
    send_frame(8'h1C, 1'b1);
    chk("par_err", 32'(err_cnt - e0), 32'd1);
    chk("par_pulse1", 32'(err_long), 32'd0);
    chk("par_keep", 32'(bus.ps2_key), 32'h175);
    send_frame(8'h1B, 1'b0);
    chk("par_next", 32'(bus.ps2_key), 32'h61B);
  endtask

  task automatic test_timeout;
    int e0;
    logic [7:0] b;
    send_frame(8'hE0, 1'b0);
    e0 = err_cnt;
    b = 8'h16;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    bus.ps2_data = 1'b1;
    @(negedge clk);
    chk("to_busy1", 32'(bus.busy), 32'd1);
    cyc(300);
    @(negedge clk);
    chk("to_busy0", 32'(bus.busy), 32'd0);
    chk("to_err", 32'(err_cnt - e0), 32'd1);
    send_frame(8'h16, 1'b0);
    chk("to_next", 32'(bus.ps2_key), 32'h216);
  endtask

  task automatic test_pause;
    logic [7:0] seq [8];
    int t0, e0;
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1,
            8'hF0, 8'h14, 8'hF0, 8'h77};
    t0 = tgl_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 8; i++) send_frame(seq[i], 1'b0);
    chk("pause_notgl", 32'(tgl_cnt - t0), 32'd0);
    chk("pause_key", 32'(bus.ps2_key), 32'h216);
    chk("pause_err", 32'(err_cnt - e0), 32'd0);
    send_frame(8'h29, 1'b0);
    chk("pause_next", 32'(bus.ps2_key), 32'h629);
  endtask

  task automatic test_glitch;
    int e0;
    e0 = err_cnt;
    busy_seen = 0;
    bus.ps2_clk = 1'b0;
    cyc(3);
    bus.ps2_clk = 1'b1;
    cyc(40);
    chk("glitch_busy", 32'(busy_seen), 32'd0);
    bus.ps2_data = 1'b1;
    bus.ps2_clk = 1'b0;
    cyc(H);
    bus.ps2_clk = 1'b1;
    cyc(40);
    chk("spur_busy", 32'(busy_seen), 32'd0);
    chk("glitch_err", 32'(err_cnt - e0), 32'd0);
    chk("glitch_key", 32'(bus.ps2_key), 32'h629);
  endtask

  task automatic test_repeat;
    int t0;
    t0 = tgl_cnt;
    send_frame(8'hFA, 1'b0);
    chk("ack_key", 32'(bus.ps2_key), 32'h629);
    send_frame(8'h1C, 1'b0);
    chk("rep_first", 32'(bus.ps2_key), 32'h21C);
    send_frame(8'h1C, 1'b0);
`ifdef PS2_REPEAT_FILTER_EN
    chk("rep_second", 32'(bus.ps2_key), 32'h21C);
    chk("rep_tgl", 32'(tgl_cnt - t0), 32'd1);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    chk("rep_brk", 32'(bus.ps2_key), 32'h41C);
    send_frame(8'h1C, 1'b0);
    chk("rep_remake", 32'(bus.ps2_key), 32'h21C);
    chk("rep_tgl3", 32'(tgl_cnt - t0), 32'd3);
`else
    chk("rep_second", 32'(bus.ps2_key), 32'h61C);
    chk("rep_tgl", 32'(tgl_cnt - t0), 32'd2);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    chk("rep_brk", 32'(bus.ps2_key), 32'h01C);
    send_frame(8'h1C, 1'b0);
    chk("rep_remake", 32'(bus.ps2_key), 32'h61C);
    chk("rep_tgl3", 32'(tgl_cnt - t0), 32'd4);
`endif
  endtask

  task automatic test_ext_ack;
    send_frame(8'hE0, 1'b0);
    send_frame(8'hFA, 1'b0);
    send_frame(8'h11, 1'b0);
`ifdef PS2_REPEAT_FILTER_EN
    chk("extack_key", 32'(bus.ps2_key), 32'h711);
`else
    chk("extack_key", 32'(bus.ps2_key), 32'h311);
`endif
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst_n = 1'b0;
    cyc(5);
    test_reset();
    rst_n = 1'b1;
    cyc(20);
    test_make();
    test_ext_break();
    test_parity_err();
    test_timeout();
    test_pause();
    test_glitch();
    test_repeat();
    test_ext_ack();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
